// File: rtl/uart_frame_loader.sv
// uart_frame_loader: frames a sync byte plus NUM_CELLS digit bytes into the puzzle store, then hands off to the solver.
// Define UART_CHECKSUM_EN to require a trailing XOR checksum byte after the last cell.
module uart_frame_loader #(
    parameter int         NUM_CELLS      = 81,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 4096,
    localparam int        ADDR_W         = $clog2(NUM_CELLS)
) (
    input  logic              uart_sampling_clk,
    input  logic              rst,
    input  logic              byte_ready,
    input  logic [7:0]        uart_byte,
    input  logic              puzzle_ack,
    output logic              cell_we,
    output logic [ADDR_W-1:0] cell_addr,
    output logic [3:0]        cell_data,
    output logic              puzzle_valid,
    output logic              rx_hold,
    output logic              frame_err,
    output logic [1:0]        err_code
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef UART_CHECKSUM_EN
    typedef enum logic [2:0] {S_SYNC, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_SYNC, S_LOAD, S_DONE, S_ERR} state_t;
`endif

    state_t            state_q, state_d;
    logic              byte_ready_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              cell_we_q, cell_we_d;
    logic [ADDR_W-1:0] cell_addr_q, cell_addr_d;
    logic [3:0]        cell_data_q, cell_data_d;
    logic              valid_q, valid_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              ev, expired;
`ifdef UART_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign ev           = byte_ready & ~byte_ready_q;
    assign expired      = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign cell_we      = cell_we_q;
    assign cell_addr    = cell_addr_q;
    assign cell_data    = cell_data_q;
    assign puzzle_valid = valid_q;
    assign rx_hold      = hold_q;
    assign frame_err    = err_q;
    assign err_code     = code_q;

    always_ff @(posedge uart_sampling_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_SYNC;
            byte_ready_q <= 1'b0;
            cnt_q        <= '0;
            timer_q      <= '0;
            cell_we_q    <= 1'b0;
            cell_addr_q  <= '0;
            cell_data_q  <= '0;
            valid_q      <= 1'b0;
            hold_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            cell_we_q    <= cell_we_d;
            cell_addr_q  <= cell_addr_d;
            cell_data_q  <= cell_data_d;
            valid_q      <= valid_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
            code_q       <= code_d;
        end
    end

`ifdef UART_CHECKSUM_EN
    always_ff @(posedge uart_sampling_clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        cell_we_d   = 1'b0;
        cell_addr_d = cell_addr_q;
        cell_data_d = cell_data_q;
        valid_d     = valid_q;
        hold_d      = hold_q;
        err_d       = 1'b0;
        code_d      = code_q;
`ifdef UART_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_SYNC: begin
                hold_d  = 1'b0;
                timer_d = '0;
                if (ev && uart_byte == SYNC_BYTE) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
`ifdef UART_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                timer_d = timer_q + 1'b1;
                if (ev) begin
                    timer_d = '0;
                    if (uart_byte > 8'd9) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        cell_we_d   = 1'b1;
                        cell_addr_d = cnt_q;
                        cell_data_d = uart_byte[3:0];
                        cnt_d       = cnt_q + 1'b1;
`ifdef UART_CHECKSUM_EN
                        csum_d      = csum_q ^ uart_byte;
                        if (cnt_q == ADDR_W'(NUM_CELLS - 1)) state_d = S_CHK;
`else
                        if (cnt_q == ADDR_W'(NUM_CELLS - 1)) begin
                            state_d = S_DONE;
                            valid_d = 1'b1;
                            hold_d  = 1'b1;
                        end
`endif
                    end
                end else if (expired) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end
            end
`ifdef UART_CHECKSUM_EN
            S_CHK: begin
                timer_d = timer_q + 1'b1;
                if (ev) begin
                    timer_d = '0;
                    state_d = (uart_byte == csum_q) ? S_DONE : S_ERR;
                    valid_d = (uart_byte == csum_q);
                    hold_d  = (uart_byte == csum_q);
                    err_d   = (uart_byte != csum_q);
                    code_d  = (uart_byte == csum_q) ? code_q : 2'd3;
                end else if (expired) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end
            end
`endif
            S_DONE: begin
                // Bytes arriving here are dropped; only the solver's ack releases the host.
                if (valid_q && puzzle_ack) begin
                    state_d = S_SYNC;
                    valid_d = 1'b0;
                    hold_d  = 1'b0;
                end
            end
            S_ERR: begin
                hold_d  = 1'b0;
                state_d = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase
    end
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: randomized frame stimulus with a queue scoreboard and a decoupled output monitor.
// Expected writes/errors/completions are derived per frame from the framing rules, not from DUT state.
module tb_uart_frame_loader;
    localparam int         N    = 81;
    localparam int         TO   = 4096;
    localparam int         AW   = $clog2(N);
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst, byte_ready, puzzle_ack;
    logic [7:0]    uart_byte;
    logic          cell_we, puzzle_valid, rx_hold, frame_err;
    logic [AW-1:0] cell_addr;
    logic [3:0]    cell_data;
    logic [1:0]    err_code;

    int checks = 0, failures = 0;
    int cyc = 0, ev_cyc = 0;
    int exp_wr[$];
    int exp_err[$];
    int exp_done = 0;
    bit pv_prev = 1'b0, fe_prev = 1'b0;

    uart_frame_loader dut (
        .uart_sampling_clk(clk),
        .rst(rst),
        .byte_ready(byte_ready),
        .uart_byte(uart_byte),
        .puzzle_ack(puzzle_ack),
        .cell_we(cell_we),
        .cell_addr(cell_addr),
        .cell_data(cell_data),
        .puzzle_valid(puzzle_valid),
        .rx_hold(rx_hold),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({cell_we, cell_addr, cell_data, puzzle_valid, rx_hold, frame_err, err_code});
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pv_prev = 1'b0;
            fe_prev = 1'b0;
        end else begin
            if (cell_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL write_unexpected addr=%0d data=%0d required=no write", cell_addr, cell_data);
                end else chk("write_addr_data", 32'({cell_addr, cell_data}), exp_wr.pop_front());
            end
            if (frame_err) begin
                chk("err_pulse_width", 32'(fe_prev), 0);
                if (exp_err.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected code=%0d required=no error", err_code);
                end else chk("err_code", 32'(err_code), exp_err.pop_front());
            end
            if (puzzle_valid && !pv_prev) begin
                checks++;
                if (exp_done == 0) begin
                    failures++;
                    $display("FAIL valid_unexpected puzzle_valid=1 required=0");
                end else exp_done--;
            end
            pv_prev = puzzle_valid;
            fe_prev = frame_err;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 uart_byte = b; byte_ready = 1'b1;
        @(posedge clk); #1 ev_cyc = cyc;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 byte_ready = 1'b0;
    endtask

    function automatic logic [7:0] cell_val(input int mode, input int i);
        case (mode)
            1:       return 8'(i % 10);
            2:       return 8'd1;
            3:       return 8'd7;
            default: return 8'($urandom_range(0, 9));
        endcase
    endfunction

    // cut_at stops sending mid-frame; slow_at delays that cell so its event lands on the expiry cycle.
    task automatic send_frame(input int mode, input int bad_at, input logic [7:0] bad_val,
                              input int cut_at, input int slow_at, input bit ignored, input bit bad_csum);
        logic [7:0] d, x;
        x = '0;
        send_byte(SYNC);
        for (int i = 0; i < N; i++) begin
            if (i == cut_at) return;
            if (i == bad_at) begin
                if (!ignored) exp_err.push_back(1);
                send_byte(bad_val);
                return;
            end
            if (i == slow_at) while (cyc < ev_cyc + TO - 2) begin @(posedge clk); #1; end
            d = cell_val(mode, i);
            x ^= d;
            if (!ignored) exp_wr.push_back(int'({i[AW-1:0], d[3:0]}));
`ifndef UART_CHECKSUM_EN
            if (!ignored && i == N - 1) exp_done++;
`endif
            send_byte(d);
        end
`ifdef UART_CHECKSUM_EN
        if (!ignored) begin
            if (bad_csum) exp_err.push_back(3);
            else exp_done++;
        end
        send_byte(bad_csum ? x ^ 8'h01 : x);
`else
        if (bad_csum) x = '0;
`endif
    endtask

    task automatic ack();
        @(posedge clk); #1 puzzle_ack = 1'b1;
        @(posedge clk); #1 puzzle_ack = 1'b0;
        chk("valid_after_ack", 32'(puzzle_valid), 0);
        chk("hold_after_ack", 32'(rx_hold), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; byte_ready = 1'b0; uart_byte = '0; puzzle_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        @(posedge clk); #1 rst = 1'b0;

        send_byte(8'h33);
        send_frame(1, -1, 8'h00, -1, -1, 1'b0, 1'b0);
        chk("valid_after_frame", 32'(puzzle_valid), 1);
        chk("hold_after_frame", 32'(rx_hold), 1);
        ack();

        send_frame(3, 5, 8'h0C, -1, -1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("bad_digit_err_gone", 32'(frame_err), 0);
        chk("bad_digit_code_held", 32'(err_code), 1);
        chk("bad_digit_hold", 32'(rx_hold), 0);
        send_frame(0, -1, 8'h00, -1, 20, 1'b0, 1'b0);
        chk("event_beats_expiry", 32'(puzzle_valid), 1);
        ack();

        exp_err.push_back(2);
        send_frame(0, -1, 8'h00, 10, -1, 1'b0, 1'b0);
        for (int k = 0; k < TO + 10 && !frame_err; k++) @(negedge clk);
        chk("timeout_latency", 32'(cyc - ev_cyc), TO);
        repeat (3) @(negedge clk);
        chk("timeout_code_held", 32'(err_code), 2);

        send_frame(0, -1, 8'h00, -1, -1, 1'b0, 1'b0);
        send_frame(0, -1, 8'h00, -1, -1, 1'b1, 1'b0);
        chk("valid_held_in_done", 32'(puzzle_valid), 1);
        chk("hold_held_in_done", 32'(rx_hold), 1);
        ack();
        send_frame(0, -1, 8'h00, -1, -1, 1'b0, 1'b0);
        ack();

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_frame(0, $urandom_range(0, N - 1), 8'($urandom_range(10, 255)), -1, -1, 1'b0, 1'b0);
                repeat (3) @(negedge clk);
            end else begin
                send_frame(0, -1, 8'h00, -1, -1, 1'b0, 1'b0);
                ack();
            end
        end

`ifdef UART_CHECKSUM_EN
        send_frame(2, -1, 8'h00, -1, -1, 1'b0, 1'b0);
        chk("csum_good_valid", 32'(puzzle_valid), 1);
        ack();
        send_frame(2, -1, 8'h00, -1, -1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("csum_bad_valid", 32'(puzzle_valid), 0);
        chk("csum_bad_code", 32'(err_code), 3);
`endif

        send_frame(0, -1, 8'h00, 40, -1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk("reset_mid_frame", outs(), 0);
        @(posedge clk); #1 rst = 1'b0;
        send_frame(0, -1, 8'h00, -1, -1, 1'b0, 1'b0);
        chk("valid_after_reset_frame", 32'(puzzle_valid), 1);
        ack();

        repeat (5) @(negedge clk);
        chk("pending_writes", 32'(exp_wr.size()), 0);
        chk("pending_errors", 32'(exp_err.size()), 0);
        chk("pending_done", 32'(exp_done), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Controller that sequences the UART byte receiver. It consumes one byte per receiver byte_ready rising edge.
- Frames a puzzle upload: a sync byte followed by NUM_CELLS cell bytes.
- Writes each cell into the puzzle store through a single-cycle write port, then hands the complete puzzle to the solver with a valid/ack handshake.
- Owns host flow control (rx_hold) and frame error detection (bad digit, inter-byte timeout).

Parameters:
- NUM_CELLS, 81, number of cell bytes per frame. Must be ≥2.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 4096, maximum uart_sampling_clk cycles between bytes inside a frame. 0 disables the timeout.
- ADDR_W, $clog2(NUM_CELLS), localparam, cell address width.

Ports:
- uart_sampling_clk  in  1  sampling clock, same clock as the receiver.
- rst  in  1  asynchronous, active-high reset.
- byte_ready  in  1  receiver level flag. Each rising edge marks one new byte.
- uart_byte  in  8  receiver byte, valid when byte_ready rises.
- puzzle_ack  in  1  solver accepts the loaded puzzle.
- cell_we  out  1  one-cycle write strobe to the puzzle store.
- cell_addr  out  ADDR_W  cell index 0..NUM_CELLS-1.
- cell_data  out  4  cell value 0..9. 0 means empty.
- puzzle_valid  out  1  complete puzzle available. Held until acked.
- rx_hold  out  1  high = host must stop sending. ORed into CTS at top level.
- frame_err  out  1  one-cycle error pulse.
- err_code  out  2  error cause. 1 = bad digit, 2 = timeout, 3 = checksum. Holds the last value until the next error.

Behaviour:
- Reset (asynchronous) forces all outputs, byte_ready_q, the cell counter, the timeout counter and the checksum to 0. State goes to S_SYNC.
- Byte event: byte_ready & ~byte_ready_q, with byte_ready_q registered every cycle. byte_ready held high produces exactly one event.
- All outputs are registered. Effects of an event at edge n are visible in the cycle after edge n.
- S_SYNC:
  - rx_hold=0.
  - Event with uart_byte==SYNC_BYTE: clear cell counter and timer, go to S_LOAD.
  - Any other byte is discarded silently.
- S_LOAD:
  - Event with uart_byte ≤ 9: cell_we=1 for one cycle, cell_addr=counter, cell_data=uart_byte[3:0], counter+1.
  - Event with uart_byte ≥ 10: no write, go to S_ERR with err_code=1.
  - Event on the last cell (counter==NUM_CELLS-1): write it, then go to S_DONE. With UART_CHECKSUM_EN, go to S_CHK instead.
  - The sync byte inside S_LOAD has no special meaning. 0xA5 > 9, so it is a bad digit.
- Timeout:
  - In S_LOAD/S_CHK the timer increments each cycle and clears on every event.
  - When timer==TIMEOUT_CYCLES-1 with no event that cycle, go to S_ERR with err_code=2.
  - If an event and expiry coincide, the event wins.
- S_DONE:
  - puzzle_valid=1, rx_hold=1.
  - Events are ignored: no writes, no error.
  - puzzle_ack is sampled only while puzzle_valid=1. On ack: puzzle_valid=0, rx_hold=0 the next cycle, go to S_SYNC.
  - puzzle_ack outside S_DONE is ignored.
- S_ERR:
  - frame_err=1 for exactly one cycle, err_code updated, rx_hold=0.
  - Return to S_SYNC.
  - Cells already written are not cleared. The next valid frame overwrites them.
- cell_addr holds its last value when cell_we=0.
- Reset mid-frame aborts with no frame_err.

Optional Feature:
- Macro: UART_CHECKSUM_EN.
- Defined:
  - S_LOAD maintains the running XOR of all cell bytes.
  - After the last cell, go to S_CHK. The next event is a checksum byte.
  - Checksum byte equals the XOR: go to S_DONE.
  - Checksum byte differs: go to S_ERR with err_code=3.
  - S_CHK is subject to the timeout.
- Undefined: no S_CHK, no checksum logic. err_code=3 is never produced.

Test Plan:
- Reset asserted mid-S_LOAD (cell 40) → all outputs 0 immediately, including puzzle_valid/rx_hold. A new 0xA5 + 81 bytes loads normally from addr 0.
- Stream 0x33, 0xA5, then bytes i%10 for i=0..80 → exactly 81 cell_we pulses, addr 0..80, data i%10, no write for 0x33. Then puzzle_valid=1 and rx_hold=1. Pulse puzzle_ack → both 0 the next cycle.
- 0xA5, cells 0..4 = 7, cell 5 = 0x0C → 5 writes, frame_err one cycle, err_code=1, state S_SYNC. A following good frame completes.
- 0xA5 + 10 bytes, then idle 4096 cycles → frame_err with err_code=2 exactly 4096 cycles after the 10th event. No further writes.
- While puzzle_valid=1, send 0xA5 + 81 bytes → zero cell_we, no frame_err, puzzle_valid still 1. After ack, a fresh frame loads.
- With UART_CHECKSUM_EN: frame of all 1s (81 bytes, XOR=0x01) plus checksum 0x01 → puzzle_valid=1. The same frame with checksum 0x00 → frame_err with err_code=3, puzzle_valid stays 0.
